// File: rtl/ita_step_scheduler_if.sv
// -----------------------------------------------------------------------------
// ita_sched_pkg / ita_step_scheduler_if
//
// Purpose : Shared types for the ITA step scheduler and the tile command bus
//           that connects the scheduler to the fetch/accumulator datapath.
//
// Types   : layer_e  - layer kind selected by the control register file
//           step_e   - compute step carried on every tile command
//           tile_t   - 32-bit tile count
//
// Interface signals (ita_step_scheduler_if, parameter HeadW = head index width)
//   cmd_valid  scheduler -> datapath   tile command valid
//   cmd_ready  datapath  -> scheduler  command accepted
//   cmd_step   scheduler -> datapath   step of the command
//   cmd_head   scheduler -> datapath   head index (0 outside attention steps)
//   cmd_row    scheduler -> datapath   row tile index
//   cmd_col    scheduler -> datapath   column tile index
//   tile_done  datapath  -> scheduler  one issued tile retired (max 1/cycle)
// Modports: master = scheduler side, slave = datapath side.
// -----------------------------------------------------------------------------
package ita_sched_pkg;

    typedef enum logic [1:0] {
        LayerAttention       = 2'd0,
        LayerFeedforward     = 2'd1,
        LayerLinear          = 2'd2,
        LayerSingleAttention = 2'd3
    } layer_e;

    typedef enum logic [3:0] {
        StepIdle   = 4'd0,
        StepQ      = 4'd1,
        StepK      = 4'd2,
        StepV      = 4'd3,
        StepQK     = 4'd4,
        StepAV     = 4'd5,
        StepOW     = 4'd6,
        StepF1     = 4'd7,
        StepF2     = 4'd8,
        StepMatMul = 4'd9
    } step_e;

    typedef logic [31:0] tile_t;

endpackage

interface ita_step_scheduler_if #(
    parameter int HeadW = 1
) ();
    import ita_sched_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    step_e            cmd_step;
    logic [HeadW-1:0] cmd_head;
    tile_t            cmd_row;
    tile_t            cmd_col;
    logic             tile_done;

    modport master (
        output cmd_valid, cmd_step, cmd_head, cmd_row, cmd_col,
        input  cmd_ready, tile_done
    );

    modport slave (
        input  cmd_valid, cmd_step, cmd_head, cmd_row, cmd_col,
        output cmd_ready, tile_done
    );

endinterface

// File: rtl/ita_step_scheduler.sv
// -----------------------------------------------------------------------------
// ita_step_scheduler
//
// Purpose : After a start pulse, walks the compute steps of one ITA layer and
//           emits one tile command per (step, head, row, col) on the command
//           bus. Tracks issued-but-not-retired tiles, drains between steps and
//           pulses done when the last tile of the layer has retired.
//
// Parameters
//   H         number of attention heads (Q..AV repeat per head, OW once)
//   MaxOutst  maximum issued-but-not-retired tiles
//
// Ports
//   clk_i          clock
//   rst_ni         asynchronous active-low reset
//   start_i        start pulse, sampled only while idle
//   layer_i        layer kind (layer_e)
//   tile_s/e/p/f_i tile geometry, latched when start is accepted
//   cmd_if         command bus (master modport), see ita_step_scheduler_if
//   busy_o         high from accepted start through the done pulse
//   done_o         one-cycle pulse when the layer has fully retired
//   perf_stall_o   (only with ITA_SCHED_PERF_EN) stall cycle counter
//
// Configuration macro: ITA_SCHED_PERF_EN adds perf_stall_o, counting cycles
// spent waiting on ready while issuing plus all drain cycles.
// -----------------------------------------------------------------------------
module ita_step_scheduler
    import ita_sched_pkg::*;
#(
    parameter int H        = 1,
    parameter int MaxOutst = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        start_i,
    input  layer_e                      layer_i,
    input  tile_t                       tile_s_i,
    input  tile_t                       tile_e_i,
    input  tile_t                       tile_p_i,
    input  tile_t                       tile_f_i,
    ita_step_scheduler_if.master        cmd_if,
    output logic                        busy_o,
    output logic                        done_o
`ifdef ITA_SCHED_PERF_EN
    ,
    output logic [31:0]                 perf_stall_o
`endif
);

    localparam int HeadW = (H > 1) ? $clog2(H) : 1;
    localparam int OutW  = (MaxOutst + 1 > 1) ? $clog2(MaxOutst + 1) : 1;
    localparam logic [OutW-1:0] MaxOutstC = OutW'(MaxOutst);

    typedef struct packed {
        step_e            step;
        logic [HeadW-1:0] head;
    } cursor_t;

    typedef struct packed {
        tile_t s;
        tile_t e;
        tile_t p;
        tile_t f;
    } tiles_t;

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    localparam cursor_t CurIdle = '{step: StepIdle, head: '0};

    // Column range of a step; rows always span tile_s.
    function automatic tile_t col_range(step_e st, tiles_t t);
        tile_t r;
        r = '0;
        case (st)
            StepQ, StepK, StepV, StepAV: r = t.p;
            StepQK:                      r = t.s;
            StepOW, StepF2, StepMatMul:  r = t.e;
            StepF1:                      r = t.f;
            default:                     r = '0;
        endcase
        return r;
    endfunction

    function automatic logic is_empty(cursor_t c, tiles_t t);
        return (t.s == '0) || (col_range(c.step, t) == '0);
    endfunction

    // Step that follows c in the layer's sequence, ignoring empty steps.
    // StepIdle as input means "before the first step"; as output, "layer over".
    function automatic cursor_t raw_next(layer_e layer, cursor_t c);
        cursor_t n;
        n = '{step: StepIdle, head: c.head};
        case (c.step)
            StepIdle: begin
                n.head = '0;
                case (layer)
                    LayerFeedforward: n.step = StepF1;
                    LayerLinear:      n.step = StepMatMul;
                    default:          n.step = StepQ;
                endcase
            end
            StepQ:  n.step = StepK;
            StepK:  n.step = StepV;
            StepV:  n.step = StepQK;
            StepQK: n.step = StepAV;
            StepAV: begin
                if (int'(c.head) == H - 1) begin
                    n.head = '0;
                    n.step = (layer == LayerAttention) ? StepOW : StepIdle;
                end else begin
                    n.head = c.head + HeadW'(1);
                    n.step = StepQ;
                end
            end
            StepF1:  n.step = StepF2;
            default: n = CurIdle;
        endcase
        return n;
    endfunction

    // Next non-empty step. With tile_s != 0 the QK step is never empty, so at
    // most four consecutive empty steps (AV, Q, K, V across a head boundary)
    // can occur; four skip iterations cover every layer.
    function automatic cursor_t find_next(layer_e layer, tiles_t t, cursor_t c);
        cursor_t n;
        if (t.s == '0) begin
            n = CurIdle;
        end else begin
            n = raw_next(layer, c);
            for (int i = 0; i < 4; i++) begin
                if (n.step != StepIdle && is_empty(n, t)) begin
                    n = raw_next(layer, n);
                end
            end
        end
        return n;
    endfunction

    state_e          r_state;
    state_e          w_state_nxt;
    layer_e          r_layer;
    tiles_t          r_tiles;
    cursor_t         r_cur;
    tile_t           r_row;
    tile_t           r_col;
    logic [OutW-1:0] r_outst;
    logic [OutW-1:0] w_outst_nxt;

    tiles_t  w_tiles_in;
    cursor_t w_first;
    cursor_t w_next;
    tile_t   w_cols;
    logic    w_valid;
    logic    w_hs;
    logic    w_done_eff;
    logic    w_last_col;
    logic    w_last_row;
    logic    w_done;

    assign w_tiles_in = '{s: tile_s_i, e: tile_e_i, p: tile_p_i, f: tile_f_i};
    assign w_first    = find_next(layer_i, w_tiles_in, CurIdle);
    // An all-empty layer enters DRAIN with an idle cursor; it must end there
    // rather than restart the sequence from the first step.
    assign w_next     = (r_cur.step == StepIdle) ? CurIdle
                                                 : find_next(r_layer, r_tiles, r_cur);

    assign w_cols     = col_range(r_cur.step, r_tiles);
    assign w_last_col = (r_col == w_cols - 32'd1);
    assign w_last_row = (r_row == r_tiles.s - 32'd1);

    assign w_valid    = (r_state == StIssue) && (r_outst < MaxOutstC);
    assign w_hs       = w_valid && cmd_if.cmd_ready;
    // A retire with nothing outstanding is dropped so the counter cannot wrap.
    assign w_done_eff = cmd_if.tile_done && (r_outst != '0);

    always_comb begin
        unique case ({w_hs, w_done_eff})
            2'b10:   w_outst_nxt = r_outst + OutW'(1);
            2'b01:   w_outst_nxt = r_outst - OutW'(1);
            default: w_outst_nxt = r_outst;
        endcase
    end

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples the values from before the edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal
        // unassigned and infers a latch.
        w_state_nxt = r_state;
        w_done      = 1'b0;
        case (r_state)
            StIdle: begin
                if (start_i) begin
                    w_state_nxt = (w_first.step == StepIdle) ? StDrain : StIssue;
                end
            end
            StIssue: begin
                if (w_hs && w_last_col && w_last_row) begin
                    w_state_nxt = StDrain;
                end
            end
            StDrain: begin
                // Leave as soon as the counter will be zero, so the next step
                // issues the cycle after the final retire.
                if (w_outst_nxt == '0) begin
                    w_state_nxt = (w_next.step == StepIdle) ? StDone : StIssue;
                end
            end
            StDone: begin
                w_done      = 1'b1;
                w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_layer <= LayerAttention;
            r_tiles <= '0;
            r_cur   <= CurIdle;
            r_row   <= '0;
            r_col   <= '0;
            r_outst <= '0;
        end else begin
            r_outst <= w_outst_nxt;
            case (r_state)
                StIdle: begin
                    if (start_i) begin
                        r_layer <= layer_i;
                        r_tiles <= w_tiles_in;
                        r_cur   <= w_first;
                        r_row   <= '0;
                        r_col   <= '0;
                    end
                end
                StIssue: begin
                    if (w_hs) begin
                        if (w_last_col) begin
                            r_col <= '0;
                            r_row <= w_last_row ? '0 : r_row + 32'd1;
                        end else begin
                            r_col <= r_col + 32'd1;
                        end
                    end
                end
                StDrain: begin
                    if (w_outst_nxt == '0) begin
                        r_cur <= w_next;
                    end
                end
                StDone:  r_cur <= CurIdle;
                default: ;
            endcase
        end
    end

`ifdef ITA_SCHED_PERF_EN
    logic [31:0] r_perf;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_perf <= '0;
        end else if (r_state == StIdle && start_i) begin
            r_perf <= '0;
        end else if (((w_valid && !cmd_if.cmd_ready) || r_state == StDrain)
                     && r_perf != '1) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign perf_stall_o = r_perf;
`endif

    assign cmd_if.cmd_valid = w_valid;
    assign cmd_if.cmd_step  = r_cur.step;
    assign cmd_if.cmd_head  = r_cur.head;
    assign cmd_if.cmd_row   = r_row;
    assign cmd_if.cmd_col   = r_col;
    assign busy_o           = (r_state != StIdle);
    assign done_o           = w_done;

    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        cmd_if.tile_done |-> (r_outst != '0));

endmodule
